// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply MAC sequencer: state encoding,
// default sizing constants and the index-counter width helper.
package mm_pkg;

    localparam int N_DEF  = 4;
    localparam int AW_DEF = 4;
    localparam int OW_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Width of an index counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mm_mac_sched_if.sv
// Handshake, operand-memory, MAC and result-memory signals of the sequencer.
// master = the sequencer, slave = the datapath / environment around it.
interface mm_mac_sched_if #(
    parameter int AW = 4,
    parameter int OW = 16
);
    logic          start;
    logic          busy;
    logic          done;
    logic          a_rd_en;
    logic [AW-1:0] a_addr;
    logic          b_rd_en;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_load;
    logic [OW-1:0] mac_acc;
    logic          c_wr_en;
    logic [AW-1:0] c_addr;
    logic [OW-1:0] c_data;

    modport master (
        input  start, mac_acc,
        output busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               mac_en, mac_load, c_wr_en, c_addr, c_data
    );

    modport slave (
        output start, mac_acc,
        input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               mac_en, mac_load, c_wr_en, c_addr, c_data
    );
endinterface

// File: rtl/mm_idx_cnt.sv
// Nested i/j/k index counter for C = A x B with wrap flags and the
// A (i*N+k), B (k*N+j) and C (i*N+j) element addresses.
module mm_idx_cnt
    import mm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          clr,     // start accepted: restart at element (0,0)
    input  logic          k_inc,   // step to the next dot-product term
    input  logic          adv,     // element written: move to the next (i,j)
    output logic          k_first,
    output logic          k_last,
    output logic          j_last,
    output logic          i_last,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] c_addr
);
    localparam int            IW   = cnt_w(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [AW-1:0] NA   = AW'(N);

    logic [IW-1:0] i, j, k;

    // Index registers; the final element leaves them untouched so the
    // addresses keep their last value until the next start.
    always_ff @(posedge clk) begin
        if (aclr || clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (adv) begin
            if (!(j_last && i_last)) begin
                k <= '0;
                if (j_last) begin
                    j <= '0;
                    i <= i + IW'(1);
                end else begin
                    j <= j + IW'(1);
                end
            end
        end else if (k_inc) begin
            k <= k + IW'(1);
        end
    end

    assign k_first = (k == '0);
    assign k_last  = (k == LAST);
    assign j_last  = (j == LAST);
    assign i_last  = (i == LAST);

    assign a_addr = AW'(i) * NA + AW'(k);
    assign b_addr = AW'(k) * NA + AW'(j);
    assign c_addr = AW'(i) * NA + AW'(j);

endmodule

// File: rtl/mm_mac_sched.sv
// Sequencer for C = A x B over one shared MAC: per C element it issues N
// operand reads, lets the MAC drain, then writes the accumulator to C.
module mm_mac_sched
    import mm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic           clk,
    input  logic           aclr,
    mm_mac_sched_if.master bus
);
    state_t state, nxt;

    logic k_first, k_last, j_last, i_last;
    logic rd;
    logic mac_en_q, mac_load_q;

    mm_idx_cnt #(.N(N), .AW(AW)) u_idx (
        .clk     (clk),
        .aclr    (aclr),
        .clr     ((state == S_IDLE) && bus.start),
        .k_inc   ((state == S_RUN) && !k_last),
        .adv     (state == S_WRITE),
        .k_first (k_first),
        .k_last  (k_last),
        .j_last  (j_last),
        .i_last  (i_last),
        .a_addr  (bus.a_addr),
        .b_addr  (bus.b_addr),
        .c_addr  (bus.c_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (aclr) state <= S_IDLE;
        else      state <= nxt;
    end

    // Next-state logic: RUN for N terms, one DRAIN, one WRITE per element.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (bus.start) nxt = S_RUN;
            S_RUN:   if (k_last) nxt = S_DRAIN;
            S_DRAIN: nxt = S_WRITE;
            S_WRITE: nxt = (i_last && j_last) ? S_DONE : S_RUN;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        rd          = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.c_wr_en = 1'b0;
        bus.c_data  = '0;
        case (state)
            S_RUN:   begin bus.busy = 1'b1; rd = 1'b1; end
            S_DRAIN: bus.busy = 1'b1;
            S_WRITE: begin
                bus.busy    = 1'b1;
                bus.c_wr_en = 1'b1;
                bus.c_data  = bus.mac_acc;
            end
            S_DONE:  begin bus.busy = 1'b1; bus.done = 1'b1; end
            default: ;
        endcase
    end

    assign bus.a_rd_en = rd;
    assign bus.b_rd_en = rd;

    // MAC control trails the read strobe by the memories' one-cycle latency;
    // the k==0 term loads the accumulator instead of adding to it.
    always_ff @(posedge clk) begin
        if (aclr) begin
            mac_en_q   <= 1'b0;
            mac_load_q <= 1'b0;
        end else begin
            mac_en_q   <= rd;
            mac_load_q <= rd && k_first;
        end
    end

    assign bus.mac_en   = mac_en_q;
    assign bus.mac_load = mac_load_q;

endmodule

// File: tb/tb_mm_mac_sched.sv
// Bench for mm_mac_sched: behavioural A/B memories and MAC around the DUT,
// a per-cycle timeline model of the run, and a C = A x B reference.
module tb_mm_mac_sched;
    import mm_pkg::*;

    localparam int N      = N_DEF;
    localparam int AW     = AW_DEF;
    localparam int OW     = OW_DEF;
    localparam int EL     = N + 2;          // cycles per C element
    localparam int RUNLEN = N * N * EL + 1; // cycle index of the done pulse

    logic clk  = 1'b0;
    logic aclr = 1'b1;
    always #5 clk = ~clk;

    mm_mac_sched_if #(.AW(AW), .OW(OW)) bus ();

    mm_mac_sched #(.N(N), .AW(AW), .OW(OW)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    // Operand memories (1-cycle read) and the MAC the sequencer drives.
    logic signed [7:0]    amem [N*N];
    logic signed [7:0]    bmem [N*N];
    logic signed [7:0]    aq = '0, bq = '0;
    logic signed [OW-1:0] acc = '0;
    logic signed [OW-1:0] ax, bx, prod;
    assign ax   = {{(OW-8){aq[7]}}, aq};
    assign bx   = {{(OW-8){bq[7]}}, bq};
    assign prod = ax * bx;
    assign bus.mac_acc = acc;

    always @(posedge clk) begin
        if (bus.a_rd_en) aq <= amem[bus.a_addr];
        if (bus.b_rd_en) bq <= bmem[bus.b_addr];
        if (bus.mac_en)  acc <= bus.mac_load ? prod : acc + prod;
    end

    // Reference results: full-precision sums and their OW-bit truncation.
    logic [OW-1:0] cexp [N*N];
    int            craw [N*N];

    task automatic build_ref();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++)
                    s += int'(amem[i*N+k]) * int'(bmem[k*N+j]);
                craw[i*N+j] = s;
                cexp[i*N+j] = s[OW-1:0];
            end
    endtask

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Run timeline: 0 = idle, 1..RUNLEN = cycle index since the accepting edge.
    int cnt    = 0;
    bit chk_en = 1'b0;
    always @(posedge clk) begin
        if (aclr) begin
            cnt    <= 0;
            chk_en <= 1'b1;
        end else if (cnt == 0) begin
            if (bus.start) cnt <= 1;
        end else if (cnt == RUNLEN) begin
            cnt <= 0;
        end else begin
            cnt <= cnt + 1;
        end
    end

    // Compare every cycle against what the timeline says must be happening.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [6:0] exp_c, act_c;
            int p, e;
            p = 0;
            e = 0;
            act_c = {bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en,
                     bus.mac_en, bus.mac_load, bus.c_wr_en};
            if (cnt == 0) begin
                exp_c = 7'b0000000;
            end else if (cnt == RUNLEN) begin
                exp_c = 7'b1100000;
            end else begin
                p = (cnt - 1) % EL;
                e = (cnt - 1) / EL;
                exp_c = {1'b1, 1'b0, p < N, p < N, (p >= 1) && (p <= N),
                         p == 1, p == N + 1};
            end
            chk("ctrl{busy,done,ard,brd,en,load,wr}", 32'(act_c), 32'(exp_c));
            if (cnt != 0 && cnt != RUNLEN) begin
                if (p < N) begin
                    chk("a_addr", 32'(bus.a_addr), 32'((e / N) * N + p));
                    chk("b_addr", 32'(bus.b_addr), 32'(p * N + (e % N)));
                end
                if (p == N + 1) begin
                    chk("c_addr", 32'(bus.c_addr), 32'(e));
                    chk("c_data", 32'(bus.c_data), 32'(cexp[e]));
                end
            end
        end
    end

    // Event counters for whole-run totals.
    int n_mac = 0, n_load = 0, n_wr = 0, n_done = 0;
    logic [OW-1:0] last_c = '0;
    always @(negedge clk) begin
        if (bus.mac_en)   n_mac++;
        if (bus.mac_load) n_load++;
        if (bus.c_wr_en) begin
            n_wr++;
            last_c = bus.c_data;
        end
        if (bus.done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (bus.done) return;
        end
        fail_now("wait_done");
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},   32'(bus.busy),   0);
        chk({tag, "_done"},   32'(bus.done),   0);
        chk({tag, "_mac_en"}, 32'(bus.mac_en), 0);
        chk({tag, "_a_addr"}, 32'(bus.a_addr), 0);
        chk({tag, "_b_addr"}, 32'(bus.b_addr), 0);
        chk({tag, "_c_addr"}, 32'(bus.c_addr), 0);
        chk({tag, "_c_data"}, 32'(bus.c_data), 0);
    endtask

    int lat, m0, l0, w0, d0, idle;

    initial begin
        bus.start = 1'b0;
        aclr      = 1'b1;
        repeat (2) tick();
        aclr = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");
        tick();

        // Identity A, B = 1..16: C must equal B.
        for (int e = 0; e < N*N; e++) begin
            amem[e] = (e / N == e % N) ? 8'sd1 : 8'sd0;
            bmem[e] = 8'(e + 1);
        end
        build_ref();
        chk("pin_id_c0",  32'(cexp[0]),  1);
        chk("pin_id_c9",  32'(cexp[9]),  10);
        chk("pin_id_c15", 32'(cexp[15]), 16);
        m0 = n_mac; l0 = n_load; w0 = n_wr; d0 = n_done;
        pulse_start();
        wait_done(lat);
        chk("id_done_latency", 32'(lat), 97);
        @(negedge clk);
        chk("id_busy_after_done", 32'(bus.busy), 0);
        chk("id_writes",   32'(n_wr - w0),   16);
        chk("id_mac_en",   32'(n_mac - m0),  64);
        chk("id_mac_load", 32'(n_load - l0), 16);
        chk("id_dones",    32'(n_done - d0), 1);
        chk("id_last_c",   32'(last_c),      16);
        tick();

        // Extreme operands, plus a stray start mid-run that must be ignored.
        for (int e = 0; e < N*N; e++) begin
            amem[e] = 8'sd127;
            bmem[e] = -8'sd128;
        end
        build_ref();
        chk("pin_ext_raw", 32'(craw[0]), 32'(-65024));
        chk("pin_ext_c0",  32'(cexp[0]), 32'h0200);
        m0 = n_mac; w0 = n_wr; d0 = n_done;
        pulse_start();
        repeat (9) tick();
        pulse_start();
        wait_done(lat);
        chk("ext_done_latency", 32'(lat), 87);
        @(negedge clk);
        chk("ext_writes", 32'(n_wr - w0),   16);
        chk("ext_mac_en", 32'(n_mac - m0),  64);
        chk("ext_dones",  32'(n_done - d0), 1);
        chk("ext_last_c", 32'(last_c),      32'h0200);
        tick();

        // Reset in cycle 40 abandons the run; a fresh run then completes.
        for (int e = 0; e < N*N; e++) begin
            amem[e] = 8'(e * 3 - 20);
            bmem[e] = 8'(7 - e * 5);
        end
        build_ref();
        chk("pin_mix_c0", 32'(cexp[0]), 1126);
        w0 = n_wr; d0 = n_done;
        pulse_start();
        repeat (38) tick();
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        @(negedge clk);
        check_idle_zero("abort");
        chk("abort_writes", 32'(n_wr - w0),   6);
        chk("abort_dones",  32'(n_done - d0), 0);
        tick();
        w0 = n_wr; d0 = n_done;
        pulse_start();
        wait_done(lat);
        chk("rerun_done_latency", 32'(lat), 97);
        @(negedge clk);
        chk("rerun_writes", 32'(n_wr - w0),   16);
        chk("rerun_dones",  32'(n_done - d0), 1);
        tick();

        // start held high: back-to-back runs with one idle cycle between.
        w0 = n_wr; d0 = n_done; idle = 0;
        bus.start = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!bus.busy) idle++;
        end
        bus.start = 1'b0;
        begin
            int t;
            t = 0;
            while (bus.busy && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) fail_now("held_drain");
        end
        @(negedge clk);
        chk("held_idle_cycles", 32'(idle),          4);
        chk("held_dones",       32'(n_done - d0),   4);
        chk("held_writes",      32'(n_wr - w0),     64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
